// File: rtl/atm_txn_arbiter_if.sv
// Session/engine handshake bundle for atm_txn_arbiter.
// The master modport is the session front-ends plus the transaction engine.
// The slave modport is the arbiter.
interface atm_txn_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic             engine_done;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             engine_start;
    logic             engine_abort;
    logic             timeout;
    logic [15:0]      txn_count;

    modport master (
        output req, engine_done,
        input  grant, grant_id, busy, engine_start, engine_abort, timeout, txn_count
    );

    modport slave (
        input  req, engine_done,
        output grant, grant_id, busy, engine_start, engine_abort, timeout, txn_count
    );
endinterface

// File: rtl/atm_txn_arbiter.sv
// Round-robin arbiter that shares one transaction engine among N_REQ sessions.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant that sits
// in WAIT for TIMEOUT_CYC cycles is aborted. When it is undefined, WAIT is left
// only on engine completion or on owner withdrawal, and timeout stays 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no owner; pick the next requester after the last owner
// S_GRANT  | grant is visible; launch the engine (start pulse next cycle)
// S_WAIT   | engine running; leave on done, withdraw, or timeout
// S_RELEASE| grant already dropped; one dead cycle before re-arbitration
module atm_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    atm_txn_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("atm_txn_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  grant_id_q;
    logic [ID_W-1:0]  last_grant_q;
    logic             busy_q;
    logic             start_q;
    logic             abort_q;
    logic [15:0]      txn_q;

    logic [ID_W-1:0]  pick_d;
    logic [ID_W-1:0]  scan_idx;
    logic             found;
    logic             owner_req;
    logic             expire;

    assign owner_req = bus.req[grant_id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    assign expire      = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Round-robin search: first pending request strictly after the last owner, wrapping.
    always_comb begin
        pick_d   = last_grant_q;
        found    = 1'b0;
        scan_idx = last_grant_q;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (scan_idx == ID_W'(N_REQ - 1)) ? '0 : scan_idx + ID_W'(1);
            if (!found && bus.req[scan_idx]) begin
                pick_d = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
            txn_q        <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        grant_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_d;
                        grant_id_q <= pick_d;
                        busy_q     <= 1'b1;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    start_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Grant drops as WAIT is left so RELEASE already shows no owner;
                    // the owner is remembered here for the next rotation.
                    if (bus.engine_done || !owner_req || expire) begin
                        grant_q      <= '0;
                        grant_id_q   <= '0;
                        last_grant_q <= grant_id_q;
                        state_q      <= S_RELEASE;
                    end
                    if (bus.engine_done) begin
                        txn_q <= txn_q + 16'd1;
                    end else if (!owner_req) begin
                        abort_q <= 1'b1;
                    end else if (expire) begin
                        abort_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_q;
    assign bus.engine_start = start_q;
    assign bus.engine_abort = abort_q;
    assign bus.txn_count    = txn_q;
endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Bench for atm_txn_arbiter (N_REQ=4, TIMEOUT_CYC=8). Adapts to ARB_TIMEOUT_EN.
module tb_atm_txn_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int OUT_DONE  = 0;
    localparam int OUT_WDRAW = 1;
    localparam int OUT_BOTH  = 2;
    localparam int OUT_TMO   = 3;

    logic clk = 1'b0;
    logic reset;

    atm_txn_arbiter_if #(.N_REQ(N)) bus ();

    atm_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_last;
    int model_txn;

    logic [9:0] obs;
    assign obs = {bus.grant, bus.grant_id, bus.busy, bus.engine_start, bus.engine_abort, bus.timeout};

    // Expected observation vector; owner < 0 means nobody holds the grant.
    function automatic logic [9:0] ev(int owner, bit b, bit s, bit a, bit t);
        logic [3:0] g;
        logic [1:0] id;
        g  = '0;
        id = '0;
        if (owner >= 0) begin
            g[owner] = 1'b1;
            id       = 2'(owner);
        end
        return {g, id, b, s, a, t};
    endfunction

    // Next owner: first pending session after the last one served, modulo N.
    function automatic int rr_next(logic [3:0] mask, int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset           = 1'b0;
        bus.req         = '0;
        bus.engine_done = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        model_last = N - 1;
        model_txn  = 0;
        @(negedge clk);
    endtask

    // One full arbitration round starting from an idle negedge.
    task automatic do_round(input logic [3:0] mask, input int outcome, input int d,
                            input bit noise, input bit early_done);
        int       own;
        int       hold;
        bit       exp_a;
        bit       exp_t;
        own     = rr_next(mask, model_last);
        bus.req = mask;
        @(negedge clk);
        checks++;
        if (obs !== ev(own, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL round_grant mask=%b got=%b exp=%b", mask, obs, ev(own, 1, 0, 0, 0));
        end
        if (early_done) bus.engine_done = 1'b1;
        @(negedge clk);
        bus.engine_done = 1'b0;
        checks++;
        if (obs !== ev(own, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL round_start got=%b exp=%b", obs, ev(own, 1, 1, 0, 0));
        end
        checks++;
        if (bus.txn_count !== 16'(model_txn)) begin
            errors++;
            $display("FAIL txn_before_done got=%0d exp=%0d", bus.txn_count, model_txn);
        end
        hold = (outcome == OUT_TMO) ? TO - 1 : d;
        if (noise) bus.req = (4'($urandom_range(0, 15)) & ~(4'b1 << own)) | (4'b1 << own);
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== ev(own, 1, 0, 0, 0)) begin
                errors++;
                $display("FAIL round_hold cyc=%0d got=%b exp=%b", c, obs, ev(own, 1, 0, 0, 0));
            end
            if (noise) bus.req = (4'($urandom_range(0, 15)) & ~(4'b1 << own)) | (4'b1 << own);
        end
        if (outcome == OUT_DONE || outcome == OUT_BOTH) bus.engine_done = 1'b1;
        if (outcome == OUT_WDRAW || outcome == OUT_BOTH) bus.req[own] = 1'b0;
        @(negedge clk);
        bus.engine_done = 1'b0;
        bus.req         = '0;
        if (outcome == OUT_DONE || outcome == OUT_BOTH) model_txn = (model_txn + 1) % 65536;
        exp_a = (outcome == OUT_WDRAW || outcome == OUT_TMO);
        exp_t = (outcome == OUT_TMO);
        checks++;
        if (obs !== ev(-1, 1, 0, exp_a, exp_t)) begin
            errors++;
            $display("FAIL round_release outcome=%0d got=%b exp=%b", outcome, obs, ev(-1, 1, 0, exp_a, exp_t));
        end
        checks++;
        if (bus.txn_count !== 16'(model_txn)) begin
            errors++;
            $display("FAIL round_txn got=%0d exp=%0d", bus.txn_count, model_txn);
        end
        model_last = own;
        @(negedge clk);
        checks++;
        if (obs !== ev(-1, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL round_idle got=%b exp=%b", obs, ev(-1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.req         = '0;
        bus.engine_done = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0 || bus.txn_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got=%b txn=%0d exp=0", obs, bus.txn_count);
        end
        do_reset();
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL reset_release got=%b exp=0", obs);
        end
    endtask

    task automatic test_single();
        do_reset();
        do_round(4'b0001, OUT_DONE, 5, 0, 0);
        checks++;
        if (bus.txn_count !== 16'd1) begin
            errors++;
            $display("FAIL single_txn got=%0d exp=1", bus.txn_count);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int r = 0; r < 5; r++) do_round(4'b1111, OUT_DONE, $urandom_range(0, TO - 1), 0, 0);
        checks++;
        if (bus.txn_count !== 16'd5) begin
            errors++;
            $display("FAIL rotation_txn got=%0d exp=5", bus.txn_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        do_round(4'b1100, OUT_TMO, 0, 0, 0);
        do_round(4'b1101, OUT_DONE, 2, 0, 0);
        checks++;
        if (bus.txn_count !== 16'd1) begin
            errors++;
            $display("FAIL timeout_txn got=%0d exp=1", bus.txn_count);
        end
    endtask

    task automatic test_no_timeout();
        do_reset();
        do_round(4'b0001, OUT_DONE, 300, 1, 0);
    endtask

    task automatic test_done_withdraw();
        do_round(4'b0110, OUT_BOTH, 3, 0, 0);
        do_round(4'b1010, OUT_WDRAW, TO - 1, 0, 0);
        do_round(4'b1111, OUT_DONE, TO - 1, 0, 0);
    endtask

    task automatic test_ignore_done();
        bus.engine_done = 1'b1;
        @(negedge clk);
        bus.engine_done = 1'b0;
        checks++;
        if (obs !== 10'b0 || bus.txn_count !== 16'(model_txn)) begin
            errors++;
            $display("FAIL idle_done got=%b txn=%0d exp=0 txn=%0d", obs, bus.txn_count, model_txn);
        end
        @(negedge clk);
        do_round(4'b0101, OUT_DONE, 2, 0, 1);
    endtask

    task automatic test_async_reset();
        do_round(4'b0010, OUT_DONE, 1, 0, 0);
        bus.req = 4'b0100;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0 || bus.txn_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got=%b txn=%0d exp=0", obs, bus.txn_count);
        end
        bus.req = '0;
        @(negedge clk);
        reset      = 1'b1;
        model_last = N - 1;
        model_txn  = 0;
        @(negedge clk);
        do_round(4'b1111, OUT_DONE, 1, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0] mask;
        int         outc;
        int         dly;
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            outc = $urandom_range(0, 3);
            if (!TO_EN && outc == OUT_TMO) outc = OUT_DONE;
            dly  = TO_EN ? $urandom_range(0, TO - 1) : $urandom_range(0, 20);
            do_round(mask, outc, dly, 1, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_done_withdraw();
        test_ignore_done();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
